// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between two writeback requesters: a
// zeroing sweep of r1..r(NUM_REGS-1) after reset, then round-robin issue from
// two per-requester queues. The optional drop counter is built only when
// REGFILE_SCHED_STATS_EN is defined.
module regfile_write_scheduler #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              write_signal,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              init_done,
  output logic              pending
`ifdef REGFILE_SCHED_STATS_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int INIT_W = $clog2(NUM_REGS) + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t             state, state_next;
  logic [INIT_W-1:0]  init_cnt;
  logic               rr_b;  // 1 when B wins the next contended cycle

  entry_t             a_mem [FIFO_DEPTH];
  entry_t             b_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   a_wp, a_rp, b_wp, b_rp;
  logic [CNT_W-1:0]   a_count, b_count, a_count_next, b_count_next;

  logic run, a_full, b_full, a_ne, b_ne;
  logic a_acc, b_acc, a_push, b_push, pop_a, pop_b;

  assign run     = (state == ST_RUN);
  assign a_full  = (a_count == CNT_W'(FIFO_DEPTH));
  assign b_full  = (b_count == CNT_W'(FIFO_DEPTH));
  assign a_ne    = (a_count != '0);
  assign b_ne    = (b_count != '0);
  assign a_ready = run & ~a_full;
  assign b_ready = run & ~b_full;

  // Writes to r0 are accepted (valid & ready) but never reach a queue.
  assign a_acc  = a_valid & a_ready;
  assign b_acc  = b_valid & b_ready;
  assign a_push = a_acc & (a_reg != '0);
  assign b_push = b_acc & (b_reg != '0);

  assign pop_a = run & a_ne & (~b_ne | ~rr_b);
  assign pop_b = run & b_ne & (~a_ne |  rr_b);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_cnt == INIT_W'(NUM_REGS)) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    a_count_next = a_count;
    b_count_next = b_count;
    case ({a_push, pop_a})
      2'b10:   a_count_next = a_count + CNT_W'(1);
      2'b01:   a_count_next = a_count - CNT_W'(1);
      default: a_count_next = a_count;
    endcase
    case ({b_push, pop_b})
      2'b10:   b_count_next = b_count + CNT_W'(1);
      2'b01:   b_count_next = b_count - CNT_W'(1);
      default: b_count_next = b_count;
    endcase
  end

  // NOTE: queue storage has no reset; the counts and pointers alone decide
  // which entries are valid, so clearing the array would only cost area.
  always_ff @(posedge clock) begin
    if (a_push) a_mem[a_wp] <= '{dst: a_reg, data: a_data};
    if (b_push) b_mem[b_wp] <= '{dst: b_reg, data: b_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt     <= INIT_W'(1);
      rr_b         <= 1'b0;
      a_wp         <= '0;
      a_rp         <= '0;
      b_wp         <= '0;
      b_rp         <= '0;
      a_count      <= '0;
      b_count      <= '0;
      write_signal <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
      init_done    <= 1'b0;
      pending      <= 1'b0;
    end else begin
      a_count <= a_count_next;
      b_count <= b_count_next;
      pending <= (a_count_next != '0) | (b_count_next != '0);
      if (a_push) a_wp <= a_wp + PTR_W'(1);
      if (b_push) b_wp <= b_wp + PTR_W'(1);
      if (pop_a)  a_rp <= a_rp + PTR_W'(1);
      if (pop_b)  b_rp <= b_rp + PTR_W'(1);

      if (state == ST_INIT) begin
        if (init_cnt != INIT_W'(NUM_REGS)) begin
          write_signal <= 1'b1;
          write_reg    <= init_cnt[ADDR_W-1:0];
          write_data   <= '0;
          init_cnt     <= init_cnt + INIT_W'(1);
        end else begin
          write_signal <= 1'b0;
          init_done    <= 1'b1;
        end
      end else if (pop_a) begin
        write_signal <= 1'b1;
        write_reg    <= a_mem[a_rp].dst;
        write_data   <= a_mem[a_rp].data;
        if (b_ne) rr_b <= 1'b1;
      end else if (pop_b) begin
        write_signal <= 1'b1;
        write_reg    <= b_mem[b_rp].dst;
        write_data   <= b_mem[b_rp].data;
        if (a_ne) rr_b <= 1'b0;
      end else begin
        write_signal <= 1'b0;
      end
    end
  end

`ifdef REGFILE_SCHED_STATS_EN
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  // Acceptance already implies RUN, so nothing is counted during the sweep.
  assign drop_inc = {1'b0, a_acc & (a_reg == '0)} + {1'b0, b_acc & (b_reg == '0)};
  assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         drop_count <= '0;
    else if (drop_sum[16]) drop_count <= 16'hFFFF;
    else                  drop_count <= drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomized and directed bench for regfile_write_scheduler against a
// queue-based reference model; compares every output on every falling edge.
module tb_regfile_write_scheduler;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_reg = '0, b_reg = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, write_signal, init_done, pending;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
`ifdef REGFILE_SCHED_STATS_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  regfile_write_scheduler dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_reg        (a_reg),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_reg        (b_reg),
    .b_data       (b_data),
    .write_signal (write_signal),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .init_done    (init_done),
`ifdef REGFILE_SCHED_STATS_EN
    .drop_count   (drop_count),
`endif
    .pending      (pending)
  );

  // Reference model: sweep index, two queues, a round-robin flag, and the
  // expected registered outputs after the most recent rising edge.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        qa[$], qb[$];
  int          m_sweep;
  bit          m_done, m_rr_b, m_ws, m_pend;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          m_drops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_sweep = 1;
    m_done  = 0;
    m_rr_b  = 0;
    m_ws    = 0;
    m_pend  = 0;
    m_wr    = '0;
    m_wd    = '0;
    m_drops = 0;
  endtask

  task automatic check_all();
    check("write_signal", 32'(write_signal), 32'(m_ws));
    check("write_reg",    32'(write_reg),    32'(m_wr));
    check("write_data",   write_data,        m_wd);
    check("init_done",    32'(init_done),    32'(m_done));
    check("pending",      32'(pending),      32'(m_pend));
    check("a_ready", 32'(a_ready), 32'(m_done && qa.size() < DEPTH));
    check("b_ready", 32'(b_ready), 32'(m_done && qb.size() < DEPTH));
`ifdef REGFILE_SCHED_STATS_EN
    check("drop_count", 32'(drop_count), 32'(m_drops > 65535 ? 65535 : m_drops));
`endif
  endtask

  // Predict the effect of the next rising edge given the inputs now driven.
  task automatic model_edge(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                            input bit bv, input logic [4:0] br, input logic [31:0] bd);
    bit   a_acc, b_acc;
    ent_t e;
    if (!m_done) begin
      if (m_sweep <= 31) begin
        m_ws = 1; m_wr = 5'(m_sweep); m_wd = '0; m_sweep++;
      end else begin
        m_ws = 0; m_done = 1;
      end
    end else begin
      a_acc = av && (qa.size() < DEPTH);
      b_acc = bv && (qb.size() < DEPTH);
      if (qa.size() != 0 && (qb.size() == 0 || !m_rr_b)) begin
        e = qa.pop_front();
        m_ws = 1; m_wr = e.r; m_wd = e.d;
        if (qb.size() != 0) m_rr_b = 1;
      end else if (qb.size() != 0) begin
        e = qb.pop_front();
        m_ws = 1; m_wr = e.r; m_wd = e.d;
        if (qa.size() != 0) m_rr_b = 0;
      end else begin
        m_ws = 0;
      end
      if (a_acc) begin
        if (ar == 0) m_drops++;
        else qa.push_back('{r: ar, d: ad});
      end
      if (b_acc) begin
        if (br == 0) m_drops++;
        else qb.push_back('{r: br, d: bd});
      end
    end
    m_pend = (qa.size() != 0) || (qb.size() != 0);
  endtask

  // Called just after a falling edge: drive, predict, advance, compare.
  task automatic tick(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    model_edge(av, ar, ad, bv, br, bd);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, '0, 0, '0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset_n = 1'b1;
    check_all();
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Sweep, then the first RUN cycle with init_done and both readies high.
    idle(32);

    // Single A write.
    tick(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    idle(3);

    // Both requesters for four beats: output alternates starting with A.
    for (int i = 1; i <= 4; i++)
      tick(1, 5'(i), 32'(i), 1, 5'(10 + i), 32'(10 + i));
    idle(10);

    // Both held valid long enough for B's queue to fill while A contends.
    for (int i = 0; i < 10; i++)
      tick(1, 5'(1 + i), 32'h100 + 32'(i), 1, 5'(16 + i), 32'h200 + 32'(i));
    idle(12);

    // Write to r0 is swallowed.
    tick(1, 5'd0, 32'h1234, 0, '0, '0);
    idle(3);

    // Reset in the middle of the sweep, at counter 10.
    apply_reset();
    idle(9);
    apply_reset();
    idle(32);

    // Random traffic with a reset mid-RUN partway through.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        apply_reset();
        idle(32);
      end
      tick($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
           $urandom,
           $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
           $urandom);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
